// File: rtl/polar_channel_sequencer.sv
// Steers strobe pulses round-robin across polarization LED channels with all-off dead time
// between channels and a frame-sync per rotation. Define FRAME_CNT_EN to add the FRAME_CNT output.
module polar_channel_sequencer #(
    parameter int NUM_CH        = 4,
    parameter int PULSES_PER_CH = 8,
    parameter int DEAD_CYCLES   = 16,
    parameter int CNT_W         = 8
) (
    input  logic              SCLOCK,
    input  logic              RESET,
    input  logic              SW17,
    input  logic [NUM_CH-1:0] SW3t0,
    input  logic              PWM_IN,
    output logic [NUM_CH-1:0] LED,
    output logic [2:0]        CH_IDX,
    output logic              FRAME_SYNC
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]       FRAME_CNT
`endif
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DEAD} state_t;

    state_t             state_reg, state_next;
    logic               pwm_q_reg;
    logic               armed_reg, armed_next;
    logic [CNT_W-1:0]   pulse_cnt_reg, pulse_cnt_next;
    logic [CNT_W-1:0]   dead_cnt_reg, dead_cnt_next;
    logic [2:0]         ch_idx_reg, ch_idx_next;
    logic               frame_sync_reg, frame_sync_next;
    logic [NUM_CH-1:0]  led_reg, led_next;
    logic [NUM_CH-1:0]  above_mask;
    logic               rise, fall, wrap;

    function automatic logic [2:0] lowest_set(input logic [NUM_CH-1:0] m);
        lowest_set = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) lowest_set = 3'(i);
    endfunction

    assign rise = PWM_IN & ~pwm_q_reg;
    assign fall = ~PWM_IN & pwm_q_reg;

    // Candidates strictly above the current channel; none left means the rotation wraps.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign above_mask[gi] = SW3t0[gi] && (3'(gi) > ch_idx_reg);
            assign led_next[gi]   = SW17 && (state_reg == ACTIVE) && (ch_idx_reg == 3'(gi))
                                    && pwm_q_reg && armed_reg;
        end
    endgenerate

    assign wrap = ~|above_mask;

    always_comb begin
        state_next      = state_reg;
        armed_next      = armed_reg;
        pulse_cnt_next  = pulse_cnt_reg;
        dead_cnt_next   = dead_cnt_reg;
        ch_idx_next     = ch_idx_reg;
        frame_sync_next = 1'b0;
        if (!SW17) begin
            state_next     = IDLE;
            armed_next     = 1'b0;
            pulse_cnt_next = '0;
            dead_cnt_next  = '0;
            ch_idx_next    = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    armed_next     = 1'b0;
                    pulse_cnt_next = '0;
                    dead_cnt_next  = '0;
                    if (|SW3t0) begin
                        state_next      = ACTIVE;
                        ch_idx_next     = lowest_set(SW3t0);
                        frame_sync_next = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (pulse_cnt_reg >= CNT_W'(PULSES_PER_CH)) begin
                        state_next     = DEAD;
                        pulse_cnt_next = '0;
                        dead_cnt_next  = '0;
                        armed_next     = 1'b0;
                    end else if (fall && armed_reg) begin
                        armed_next     = 1'b0;
                        pulse_cnt_next = pulse_cnt_reg + CNT_W'(1);
                    end else if (rise) begin
                        // Only rises seen inside ACTIVE arm the channel, so partial pulses are dropped.
                        armed_next = 1'b1;
                    end
                end
                DEAD: begin
                    armed_next = 1'b0;
                    if (dead_cnt_reg >= CNT_W'(DEAD_CYCLES - 1)) begin
                        dead_cnt_next = '0;
                        if (|SW3t0) begin
                            state_next      = ACTIVE;
                            ch_idx_next     = wrap ? lowest_set(SW3t0) : lowest_set(above_mask);
                            frame_sync_next = wrap;
                        end else begin
                            state_next  = IDLE;
                            ch_idx_next = '0;
                        end
                    end else begin
                        dead_cnt_next = dead_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge SCLOCK) begin
        if (RESET) begin
            state_reg      <= IDLE;
            pwm_q_reg      <= 1'b0;
            armed_reg      <= 1'b0;
            pulse_cnt_reg  <= '0;
            dead_cnt_reg   <= '0;
            ch_idx_reg     <= '0;
            frame_sync_reg <= 1'b0;
            led_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            pwm_q_reg      <= PWM_IN;
            armed_reg      <= armed_next;
            pulse_cnt_reg  <= pulse_cnt_next;
            dead_cnt_reg   <= dead_cnt_next;
            ch_idx_reg     <= ch_idx_next;
            frame_sync_reg <= frame_sync_next;
            led_reg        <= led_next;
        end
    end

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge SCLOCK) begin
        if (RESET)
            frame_cnt_reg <= '0;
        else if (frame_sync_next)
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end

    assign FRAME_CNT = frame_cnt_reg;
`endif

    assign LED        = led_reg;
    assign CH_IDX     = ch_idx_reg;
    assign FRAME_SYNC = frame_sync_reg;

endmodule

// File: tb/tb_polar_channel_sequencer.sv
// Directed bench for polar_channel_sequencer with PULSES_PER_CH=2, DEAD_CYCLES=3, four channels.
module tb_polar_channel_sequencer;

    logic       SCLOCK, RESET, SW17, PWM_IN;
    logic [3:0] SW3t0, LED;
    logic [2:0] CH_IDX;
    logic       FRAME_SYNC;
`ifdef FRAME_CNT_EN
    logic [15:0] FRAME_CNT;
`endif

    int   total, bad, fs_seen, multi_hot;
    logic lane13;

    polar_channel_sequencer #(
        .NUM_CH(4), .PULSES_PER_CH(2), .DEAD_CYCLES(3), .CNT_W(8)
    ) dut (
        .SCLOCK(SCLOCK), .RESET(RESET), .SW17(SW17), .SW3t0(SW3t0), .PWM_IN(PWM_IN),
        .LED(LED), .CH_IDX(CH_IDX), .FRAME_SYNC(FRAME_SYNC)
`ifdef FRAME_CNT_EN
        , .FRAME_CNT(FRAME_CNT)
`endif
    );

    initial SCLOCK = 1'b0;
    always #5 SCLOCK = ~SCLOCK;

    task automatic tick();
        @(posedge SCLOCK);
        #1;
    endtask

    task automatic step(input logic p);
        PWM_IN = p;
        tick();
        if ($countones(LED) > 1) multi_hot++;
        if (FRAME_SYNC) fs_seen++;
        lane13 = lane13 | LED[1] | LED[3];
    endtask

    task automatic chk(input string tag, input logic [3:0] el, input logic [2:0] ec, input logic ef);
        $display("[%0t] %s LED=%b CH_IDX=%0d FRAME_SYNC=%b", $time, tag, LED, CH_IDX, FRAME_SYNC);
        total++;
        assert (LED === el) else begin
            bad++; $error("FAIL %s.led observed=%b expected=%b", tag, LED, el);
        end
        total++;
        assert (CH_IDX === ec) else begin
            bad++; $error("FAIL %s.ch_idx observed=%0d expected=%0d", tag, CH_IDX, ec);
        end
        total++;
        assert (FRAME_SYNC === ef) else begin
            bad++; $error("FAIL %s.frame_sync observed=%b expected=%b", tag, FRAME_SYNC, ef);
        end
    endtask

    task automatic chk_lf(input string tag, input logic [3:0] el, input logic ef);
        $display("[%0t] %s LED=%b FRAME_SYNC=%b", $time, tag, LED, FRAME_SYNC);
        total++;
        assert (LED === el) else begin
            bad++; $error("FAIL %s.led observed=%b expected=%b", tag, LED, el);
        end
        total++;
        assert (FRAME_SYNC === ef) else begin
            bad++; $error("FAIL %s.frame_sync observed=%b expected=%b", tag, FRAME_SYNC, ef);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        $display("[%0t] %s value=%0d", $time, tag, obs);
        total++;
        assert (obs === exp) else begin
            bad++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reset pulse then one enabled edge: after start() the IDLE->ACTIVE edge (edge 1) has passed.
    task automatic start(input logic [3:0] mask);
        RESET = 1'b1; SW17 = 1'b0; PWM_IN = 1'b0;
        tick();
        RESET = 1'b0; SW17 = 1'b1; SW3t0 = mask;
        fs_seen = 0; multi_hot = 0; lane13 = 1'b0;
        tick();
    endtask

    initial begin
        total = 0; bad = 0; fs_seen = 0; multi_hot = 0; lane13 = 1'b0;
        RESET = 1'b1; SW17 = 1'b1; SW3t0 = 4'b1111; PWM_IN = 1'b0;

        for (int i = 0; i < 3; i++) begin
            PWM_IN = ~PWM_IN;
            tick();
            chk("reset_hold", 4'b0000, 3'd0, 1'b0);
        end

        // Basic rotation: PWM 4 high / 4 low starting at edge 2.
        start(4'b1111);
        chk("rot_entry0", 4'b0000, 3'd0, 1'b1);
        for (int e = 2; e <= 112; e++) begin
            step(((e - 2) % 8) < 4);
            case (e)
                2, 7, 15, 17:          chk("rot_ch0_off", 4'b0000, 3'd0, 1'b0);
                3, 6, 11, 14, 99, 107: chk("rot_ch0_on", 4'b0001, 3'd0, 1'b0);
                18, 20, 26, 31:        chk("rot_ch1_off", 4'b0000, 3'd1, 1'b0);
                27, 30, 35:            chk("rot_ch1_on", 4'b0010, 3'd1, 1'b0);
                42:                    chk("rot_ch2_entry", 4'b0000, 3'd2, 1'b0);
                51, 59:                chk("rot_ch2_on", 4'b0100, 3'd2, 1'b0);
                66:                    chk("rot_ch3_entry", 4'b0000, 3'd3, 1'b0);
                75, 83:                chk("rot_ch3_on", 4'b1000, 3'd3, 1'b0);
                90:                    chk("rot_wrap_entry0", 4'b0000, 3'd0, 1'b1);
                91:                    chk("rot_after_sync", 4'b0000, 3'd0, 1'b0);
                default: ;
            endcase
        end
        chk_int("rot_fs_count", fs_seen, 1);
        chk_int("rot_multi_hot", multi_hot, 0);
`ifdef FRAME_CNT_EN
        chk_int("rot_frame_cnt", int'(FRAME_CNT), 2);
`endif
        SW17 = 1'b0;
        step(1'b0);
        chk("rot_sw17_drop", 4'b0000, 3'd0, 1'b0);
`ifdef FRAME_CNT_EN
        chk_int("rot_frame_cnt_held", int'(FRAME_CNT), 2);
`endif
        SW17 = 1'b1;
        step(1'b0);
        chk("rot_reenable", 4'b0000, 3'd0, 1'b1);
`ifdef FRAME_CNT_EN
        chk_int("rot_frame_cnt_inc", int'(FRAME_CNT), 3);
`endif

        // Skip mask 0101: channels 0 and 2 only.
        start(4'b0101);
        chk("skip_entry0", 4'b0000, 3'd0, 1'b1);
        for (int e = 2; e <= 92; e++) begin
            step(((e - 2) % 8) < 4);
            case (e)
                3, 51:  chk("skip_ch0_on", 4'b0001, 3'd0, 1'b0);
                18, 66: chk("skip_ch2_entry", 4'b0000, 3'd2, 1'b0);
                27, 75: chk("skip_ch2_on", 4'b0100, 3'd2, 1'b0);
                42, 90: chk("skip_wrap_entry0", 4'b0000, 3'd0, 1'b1);
                default: ;
            endcase
        end
        chk_int("skip_fs_count", fs_seen, 2);
        chk_int("skip_lane13", int'(lane13), 0);

        // Single channel 0100: re-entry to channel 2 after each dead gap.
        start(4'b0100);
        chk("single_entry", 4'b0000, 3'd2, 1'b1);
        for (int e = 2; e <= 44; e++) begin
            step(((e - 2) % 8) < 4);
            case (e)
                3, 27:  chk("single_on", 4'b0100, 3'd2, 1'b0);
                15, 19: chk("single_off", 4'b0000, 3'd2, 1'b0);
                18, 42: chk("single_reentry", 4'b0000, 3'd2, 1'b1);
                default: ;
            endcase
        end
        chk_int("single_fs_count", fs_seen, 2);

        // Partial pulses: rise inside DEAD (edge 9) and rise one cycle before DEAD exit (edge 25).
        start(4'b0011);
        chk("part_entry0", 4'b0000, 3'd0, 1'b1);
        for (int e = 2; e <= 34; e++) begin
            step(e inside {2, 3, 5, 6, 9, 10, 11, 12, 13, 16, 17, 20, 21, 25, 26, 27, 28, 31, 32});
            case (e)
                3:              chk("part_ch0_on", 4'b0001, 3'd0, 1'b0);
                8:              chk("part_dead0", 4'b0000, 3'd0, 1'b0);
                11, 12, 15:     chk("part_a_dropped", 4'b0000, 3'd1, 1'b0);
                17, 18, 21:     chk("part_a_next_full", 4'b0010, 3'd1, 1'b0);
                19, 23:         chk("part_ch1_off", 4'b0000, 3'd1, 1'b0);
                26:             chk("part_b_entry0", 4'b0000, 3'd0, 1'b1);
                27, 28, 30, 34: chk("part_b_dropped", 4'b0000, 3'd0, 1'b0);
                32, 33:         chk("part_b_next_full", 4'b0001, 3'd0, 1'b0);
                default: ;
            endcase
        end

        // SW17 dropped mid-pulse on channel 1.
        start(4'b1111);
        for (int e = 2; e <= 28; e++) step(((e - 2) % 8) < 4);
        chk("drop_ch1_on", 4'b0010, 3'd1, 1'b0);
        SW17 = 1'b0;
        step(1'b1);
        chk("drop_mid_pulse", 4'b0000, 3'd0, 1'b0);
        step(1'b0);
        chk("drop_idle_hold", 4'b0000, 3'd0, 1'b0);
        SW17 = 1'b1;
        step(1'b0);
        chk("drop_reenter", 4'b0000, 3'd0, 1'b1);

        // Mask cleared during DEAD: sequencer parks in IDLE at DEAD exit.
        start(4'b0011);
        for (int e = 2; e <= 40; e++) begin
            if (e == 16) SW3t0 = 4'b0000;
            step(((e - 2) % 8) < 4);
            case (e)
                15:         chk("mz_dead", 4'b0000, 3'd0, 1'b0);
                18, 27, 30: chk_lf("mz_parked", 4'b0000, 1'b0);
                default: ;
            endcase
        end
        SW3t0 = 4'b0001;
        step(1'b0);
        chk("mz_restart", 4'b0000, 3'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/polar_channel_sequencer.md
Name: polar_channel_sequencer

Overview:
- Downstream of the stroboscopic PWM generator; consumes its strobe output and steers each strobe pulse to one LED channel.
- Each LED channel is one polarization angle.
- Rotates round-robin through the enabled channels, after a fixed number of pulses per channel, with all-off dead time between channels.
- Emits a frame-sync pulse once per complete rotation, for camera triggering.

Parameters:
- NUM_CH, 4, number of LED/polarization channels (2..8).
- PULSES_PER_CH, 8, strobe pulses forwarded per channel before advancing (>=1).
- DEAD_CYCLES, 16, SCLOCK cycles with all LEDs off between channels (>=1).
- CNT_W, 8, width of the pulse and dead-time counters; must hold max(PULSES_PER_CH, DEAD_CYCLES).

Ports:
- SCLOCK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- SW17  in  1  sequencer enable (1 = run).
- SW3t0  in  NUM_CH  channel enable mask; bit i enables channel i.
- PWM_IN  in  1  strobe from the stroboscopic PWM stage; synchronous to SCLOCK.
- LED  out  NUM_CH  per-channel drive; at most one bit high.
- CH_IDX  out  3  index of the current channel.
- FRAME_SYNC  out  1  one-cycle pulse at the start of each rotation.

Behaviour:
- Reset values: LED=0, CH_IDX=0, FRAME_SYNC=0, state=IDLE, pwm_q=0, counters=0, armed=0.
- Edge detect: pwm_q registers PWM_IN.
  - rise = PWM_IN & ~pwm_q
  - fall = ~PWM_IN & pwm_q
- FSM has three states: IDLE, ACTIVE, DEAD.
- IDLE:
  - LED=0.
  - If SW17=1 and SW3t0!=0: go to ACTIVE with CH_IDX = lowest set mask bit, pulse count = 0, FRAME_SYNC=1 for that cycle.
- ACTIVE:
  - On a rise, set armed=1.
  - LED[CH_IDX] = pwm_q & armed, registered, so LED lags PWM_IN by exactly 2 cycles.
  - On a fall while armed: pulse count +1 and armed=0.
  - When the count reaches PULSES_PER_CH, go to DEAD next cycle and clear the count.
- DEAD:
  - LED=0 and armed held 0; rises during DEAD are never forwarded.
  - Counts DEAD_CYCLES cycles, then samples SW3t0 and selects the next enabled index strictly greater than CH_IDX, modulo NUM_CH.
  - If the search wraps (next <= CH_IDX, including a single enabled channel), FRAME_SYNC=1 on the cycle ACTIVE is entered.
  - If the sampled mask is 0, go to IDLE.
- Partial pulses: a pulse already high when ACTIVE is entered is not forwarded; only pulses whose rise occurs in ACTIVE are forwarded.
- Mask sampling: SW3t0 is sampled only at IDLE exit and at DEAD exit. A mask change mid-channel does not cut the current channel short.
- SW17=0 in any state: next cycle go to IDLE, LED=0, CH_IDX=0, counters cleared, even mid-pulse (the pulse is truncated).
- RESET overrides everything, including mid-pulse and mid-DEAD.
- FRAME_SYNC is never high for more than one consecutive cycle.

Optional Feature:
- Macro: FRAME_CNT_EN.
- When defined:
  - Extra output FRAME_CNT out 16 counts FRAME_SYNC pulses.
  - Reset value 0; wraps 0xFFFF -> 0.
  - Held, not cleared, when SW17 drops.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold RESET 3 cycles with PWM_IN toggling -> LED=0, CH_IDX=0, FRAME_SYNC=0 throughout.
- Basic rotation:
  - Setup: PULSES_PER_CH=2, DEAD_CYCLES=3, SW17=1, SW3t0=4'b1111; PWM 4 cycles high / 4 low.
  - LED sequence: 0001,0001,0010,0010,0100,0100,1000,1000, then back to 0001.
  - Each LED edge lags PWM_IN by 2 cycles.
  - 3 all-off cycles between channels.
  - FRAME_SYNC pulses exactly at the two entries to channel 0.
- Skip mask: SW3t0=4'b0101 -> CH_IDX alternates 0,2,0,2; FRAME_SYNC on every entry to channel 0; LED[1] and LED[3] never high.
- Single channel: SW3t0=4'b0100 -> CH_IDX stays 2; dead gap inserted every 2 pulses; FRAME_SYNC at each re-entry.
- Dead-time and partial pulse:
  - A PWM rise during DEAD, still high when ACTIVE is entered -> that pulse is not forwarded; the next full pulse is.
  - Same check with the rise 1 cycle before DEAD exit.
- Enable and mask drop:
  - SW17 dropped mid-pulse on channel 1 -> LED=0 next cycle, CH_IDX=0, state IDLE.
  - With SW17=1, mask set to 0 during DEAD -> IDLE at DEAD exit, LED stays 0.
  - With FRAME_CNT_EN defined: FRAME_CNT=2 after two rotations, and it is retained across the SW17 drop.
